// File: rtl/system_memory_pkg.sv
// Shared types for the Game-of-Life cell-state memory: mode encoding and
// the fixed-priority mode decoder (RUN > LOAD > OUTPUT > IDLE).
package system_memory_pkg;

   localparam int unsigned DEFAULT_DATA_SIZE = 5;

   typedef enum logic [1:0] {
      MODE_IDLE   = 2'd0,
      MODE_OUTPUT = 2'd1,
      MODE_LOAD   = 2'd2,
      MODE_RUN    = 2'd3
   } sysmem_mode_e;

   function automatic sysmem_mode_e decode_mode(input logic run,
                                                input logic load,
                                                input logic out_req);
      if (run)
         return MODE_RUN;
      else if (load)
         return MODE_LOAD;
      else if (out_req)
         return MODE_OUTPUT;
      else
         return MODE_IDLE;
   endfunction

endpackage

// File: rtl/sysmem_out_shifter.sv
// Parallel-load / serial-out shadow register feeding SERIAL_OUT, MSB first.
// Define SYSTEM_MEMORY_OUT_WRAP_EN to rotate the shadow instead of zero-filling.
module sysmem_out_shifter #(
   parameter int unsigned DATA_SIZE = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_shift,
   input  logic [DATA_SIZE-1:0] i_data,
   output logic                 o_serial
);

   logic [DATA_SIZE-1:0] r_shadow;
   logic                 r_serial;
   logic                 w_fill;

`ifdef SYSTEM_MEMORY_OUT_WRAP_EN
   assign w_fill = r_shadow[DATA_SIZE-1];
`else
   assign w_fill = 1'b0;
`endif

   // Any non-shift cycle reloads from the next memory value and idles the line low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
         r_serial <= 1'b0;
      end else if (i_shift) begin
         r_serial <= r_shadow[DATA_SIZE-1];
         r_shadow <= {r_shadow[DATA_SIZE-2:0], w_fill};
      end else begin
         r_shadow <= i_data;
         r_serial <= 1'b0;
      end
   end

   assign o_serial = r_serial;

endmodule

// File: rtl/system_memory_v3.sv
// Cell-state memory: serial load, parallel load from grid logic, serial read-out.
// Optional read-out wrap via SYSTEM_MEMORY_OUT_WRAP_EN (in sysmem_out_shifter).
module system_memory_v3 #(
   parameter int unsigned DATA_SIZE = 5
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [DATA_SIZE-1:0] GRID_IN,
   input  logic                 SERIAL_IN,
   input  logic                 LOAD_MODE,
   input  logic                 RUN_MODE,
   input  logic                 OUTPUT_MODE,
   output logic [DATA_SIZE-1:0] SYSTEM_MEM_OUT,
   output logic                 SERIAL_OUT
);

   import system_memory_pkg::*;

   sysmem_mode_e         w_mode;
   logic [DATA_SIZE-1:0] w_mem_next;
   logic [DATA_SIZE-1:0] r_mem;
   logic                 w_shift;

   assign w_mode  = decode_mode(RUN_MODE, LOAD_MODE, OUTPUT_MODE);
   assign w_shift = (w_mode == MODE_OUTPUT);

   // Next-state mux for the stored vector
   always_comb begin
      w_mem_next = r_mem;
      case (w_mode)
         MODE_RUN:  w_mem_next = GRID_IN;
         MODE_LOAD: w_mem_next = {r_mem[DATA_SIZE-2:0], SERIAL_IN};
         default:   w_mem_next = r_mem;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         r_mem <= '0;
      else
         r_mem <= w_mem_next;
   end

   sysmem_out_shifter #(
      .DATA_SIZE(DATA_SIZE)
   ) u_out_shifter (
      .clk      (CLK),
      .rst_n    (RESET),
      .i_shift  (w_shift),
      .i_data   (w_mem_next),
      .o_serial (SERIAL_OUT)
   );

   assign SYSTEM_MEM_OUT = r_mem;

endmodule

// File: tb/tb_system_memory_v3.sv
// Bench for system_memory_v3: directed literal checks plus randomized modes
// compared every cycle against a read-out-index reference model.
module tb_system_memory_v3;

   localparam int unsigned N    = 5;
   localparam int unsigned MASK = (1 << N) - 1;

   logic         CLK;
   logic         RESET;
   logic [N-1:0] GRID_IN;
   logic         SERIAL_IN;
   logic         LOAD_MODE;
   logic         RUN_MODE;
   logic         OUTPUT_MODE;
   logic [N-1:0] SYSTEM_MEM_OUT;
   logic         SERIAL_OUT;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 0;

   system_memory_v3 #(.DATA_SIZE(N)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .GRID_IN        (GRID_IN),
      .SERIAL_IN      (SERIAL_IN),
      .LOAD_MODE      (LOAD_MODE),
      .RUN_MODE       (RUN_MODE),
      .OUTPUT_MODE    (OUTPUT_MODE),
      .SYSTEM_MEM_OUT (SYSTEM_MEM_OUT),
      .SERIAL_OUT     (SERIAL_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: the vector being streamed and how many bits have gone out
   int unsigned m_mem, m_vec, m_idx;
   int unsigned m_sout;

   always @(posedge CLK or negedge RESET) begin
      int unsigned k;
      if (!RESET) begin
         m_mem = 0; m_vec = 0; m_idx = 0; m_sout = 0;
      end else if (RUN_MODE || LOAD_MODE || !OUTPUT_MODE) begin
         if (RUN_MODE)       m_mem = GRID_IN;
         else if (LOAD_MODE) m_mem = ((m_mem << 1) | SERIAL_IN) & MASK;
         m_vec  = m_mem;
         m_idx  = 0;
         m_sout = 0;
      end else begin
`ifdef SYSTEM_MEMORY_OUT_WRAP_EN
         k = m_idx % N;
`else
         k = m_idx;
`endif
         m_sout = (k < N) ? ((m_vec >> (N - 1 - k)) & 1) : 0;
         m_idx  = m_idx + 1;
      end
   end

   always @(negedge CLK) begin
      if (cmp_en) begin
         checks = checks + 2;
         if (int'(SYSTEM_MEM_OUT) != m_mem) begin
            failures = failures + 1;
            $display("FAIL cyc_mem t=%0t got=%0h exp=%0h", $time, SYSTEM_MEM_OUT, m_mem);
         end
         if (int'(SERIAL_OUT) != m_sout) begin
            failures = failures + 1;
            $display("FAIL cyc_sout t=%0t got=%0d exp=%0d", $time, SERIAL_OUT, m_sout);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then return 1 time unit after the rising edge
   task automatic drive(input bit run, input bit load, input bit outm,
                        input logic [N-1:0] grid, input bit sin);
      RUN_MODE = run; LOAD_MODE = load; OUTPUT_MODE = outm;
      GRID_IN = grid; SERIAL_IN = sin;
      @(posedge CLK);
      #1;
   endtask

   // Mid-cycle reset: outputs must clear with no clock edge
   task automatic pulse_reset(input string name);
      #1;
      RESET = 1'b0;
      #1;
      chk({name, "_mem"},  int'(SYSTEM_MEM_OUT), 0);
      chk({name, "_sout"}, int'(SERIAL_OUT), 0);
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [N-1:0] exp_bits;
      RESET = 1'b0;
      RUN_MODE = 0; LOAD_MODE = 0; OUTPUT_MODE = 0; GRID_IN = '0; SERIAL_IN = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      cmp_en = 1;
      @(posedge CLK);
      #1;
      chk("reset_mem",  int'(SYSTEM_MEM_OUT), 0);
      chk("reset_sout", int'(SERIAL_OUT), 0);

      // Idle with distracting inputs
      repeat (20) drive(0, 0, 0, 5'b11001, 1);
      chk("idle_mem",  int'(SYSTEM_MEM_OUT), 0);
      chk("idle_sout", int'(SERIAL_OUT), 0);

      // Serial load 1,0,0,1
      drive(0, 1, 0, 5'b00110, 1);
      chk("load1_mem", int'(SYSTEM_MEM_OUT), 5'b00001);
      chk("load1_sout", int'(SERIAL_OUT), 0);
      drive(0, 1, 0, 5'b00110, 0);
      drive(0, 1, 0, 5'b00110, 0);
      drive(0, 1, 0, 5'b00110, 1);
      chk("load4_mem", int'(SYSTEM_MEM_OUT), 5'b01001);
      chk("load4_sout", int'(SERIAL_OUT), 0);

      // RUN beats LOAD, then hold, then async reset
      drive(1, 1, 0, 5'b00110, 1);
      chk("runload_mem", int'(SYSTEM_MEM_OUT), 5'b00110);
      drive(0, 0, 0, 5'b11111, 1);
      drive(0, 0, 0, 5'b11111, 1);
      chk("hold_mem", int'(SYSTEM_MEM_OUT), 5'b00110);
      pulse_reset("rst_a");

      // Parallel load then stream MSB first
      drive(1, 0, 0, 5'b01101, 0);
      exp_bits = 5'b01101;
      for (int i = 0; i < N; i++) begin
         drive(0, 0, 1, 5'b10010, 1);
         chk($sformatf("stream_bit%0d", i), int'(SERIAL_OUT), int'(exp_bits[N-1-i]));
         chk($sformatf("stream_mem%0d", i), int'(SYSTEM_MEM_OUT), 5'b01101);
      end
      drive(0, 0, 1, 5'b10010, 1);
      chk("stream_bit5", int'(SERIAL_OUT), 0);

      // Priority corner cases
      pulse_reset("rst_b");
      drive(0, 1, 1, 5'b00000, 1);
      chk("outload_mem",  int'(SYSTEM_MEM_OUT), 5'b00001);
      chk("outload_sout", int'(SERIAL_OUT), 0);
      drive(1, 1, 0, 5'b11011, 0);
      chk("runload2_mem", int'(SYSTEM_MEM_OUT), 5'b11011);
      drive(1, 0, 1, 5'b00110, 0);
      chk("runout_mem",  int'(SYSTEM_MEM_OUT), 5'b00110);
      chk("runout_sout", int'(SERIAL_OUT), 0);

      // Reset in the middle of a read-out
      drive(1, 0, 0, 5'b11111, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 5'b00000, 0);
      chk("midread_bit2", int'(SERIAL_OUT), 1);
      pulse_reset("rst_c");
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 1, 5'b11111, 1);
         chk($sformatf("postrst_sout%0d", i), int'(SERIAL_OUT), 0);
      end

      // Randomized modes with occasional reset
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) == 0) pulse_reset("rst_rand");
         drive(bit'($urandom_range(0, 99) < 12), bit'($urandom_range(0, 99) < 25),
               bit'($urandom_range(0, 99) < 75), N'($urandom), bit'($urandom_range(0, 1)));
      end

      @(negedge CLK);
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
